seq_shift_add_mult: RTL and testbench

- Parametrised sequential shift-add multiplier, one operand bit per cycle; controller FSM and datapath in one block.
- Generalises the fixed 4-cycle start/done unit:
  - WIDTH-bit operands.
  - Signed or unsigned mode per operation.
  - valid/ready handshakes on both input and output.
  - Optional early termination.
- Sits between an operand producer and a result consumer in the arithmetic pipeline.

---
 rtl/seq_shift_add_mult_pkg.sv | 23 ++
 rtl/seq_shift_add_mult_if.sv | 31 +++
 rtl/seq_shift_add_mult_datapath.sv | 101 ++++++++++
 rtl/seq_shift_add_mult.sv | 125 ++++++++++++
 tb/tb_seq_shift_add_mult.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_shift_add_mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-add multiplier:
//   state_t   - controller states (IDLE, MUL, DONE)
//   cnt_width - width of the iteration counter for a given operand width
// No ports (package).
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to hold 0 .. WIDTH-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult_if
// Handshake bundle between an operand producer / result consumer (master) and
// the multiplier (slave).
//   in_valid/in_ready       : operand handshake, with a, b, signed_mode
//   out_valid/out_ready     : result handshake, with product (2*WIDTH bits)
//   busy                    : multiplier is not idle
// -----------------------------------------------------------------------------
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_shift_add_mult_datapath.sv
// -----------------------------------------------------------------------------
// seq_mult_datapath
// Accumulator / multiplicand / multiplier registers and the shift-add step for
// the sequential multiplier. Operands are reduced to magnitudes on load and the
// sign is re-applied when the final product is registered.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load            : capture operands (magnitudes, sign), clear accumulator
//   step            : one iteration: shift mcand left, mplier right
//   add             : add mcand into the accumulator on this step
//   finish          : register the signed product (includes this edge's add)
//   a, b            : raw operands
//   signed_mode     : operands are two's complement
//   mplier_zero     : remaining multiplier bits are all zero
//   mplier_lsb      : current multiplier bit
//   product         : registered 2*WIDTH-bit result
// -----------------------------------------------------------------------------
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 add,
  input  logic                 finish,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 mplier_zero,
  output logic                 mplier_lsb,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_sum;

  always_comb begin
    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so WIDTH bits are enough.
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    acc_sum = acc_q + (add ? mcand_q : '0);

    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end

    // acc_sum already holds the last partial product, so the result is ready
    // on the same edge as the final iteration.
    if (finish) begin
      product_d = neg_q ? (-acc_sum) : acc_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign mplier_zero = (mplier_q == '0);
  assign mplier_lsb  = mplier_q[0];
  assign product     = product_q;

endmodule

// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
// Sequential shift-add multiplier, one multiplier bit per cycle, with
// valid/ready handshakes on operands and result. One operation in flight.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset
//   bus   : slave side of seq_shift_add_mult_if (operands, mode, product,
//           both handshakes, busy)
// Parameters:
//   WIDTH      : operand width (>= 2), product is 2*WIDTH bits
//   EARLY_TERM : 1 = stop as soon as the remaining multiplier bits are zero
// -----------------------------------------------------------------------------
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_shift_add_mult_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;

  logic            load;
  logic            step;
  logic            add;
  logic            finish;
  logic            mplier_zero;
  logic            mplier_lsb;
  logic [2*WIDTH-1:0] product;

  seq_mult_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .add         (add),
    .finish      (finish),
    .a           (bus.a),
    .b           (bus.b),
    .signed_mode (bus.signed_mode),
    .mplier_zero (mplier_zero),
    .mplier_lsb  (mplier_lsb),
    .product     (product)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    step        = 1'b0;
    add         = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // in_ready is high in IDLE, so in_valid alone completes the handshake.
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = MUL;
        end
      end

      MUL: begin
        if (EARLY_TERM && mplier_zero) begin
          // Nothing left to add: the accumulator is already the magnitude.
          finish      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          step  = 1'b1;
          add   = mplier_lsb;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            finish      = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        // in_valid is ignored here; the next accept waits for IDLE.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

  localparam int W = 8;

  logic clk;
  logic rst;

  logic         drv_in_valid;
  logic [W-1:0] drv_a;
  logic [W-1:0] drv_b;
  logic         drv_sm;
  logic         drv_out_ready;

  int checks   = 0;
  int failures = 0;

  seq_shift_add_mult_if #(.WIDTH(W)) bus0 ();
  seq_shift_add_mult_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_valid    = drv_in_valid;
  assign bus0.a           = drv_a;
  assign bus0.b           = drv_b;
  assign bus0.signed_mode = drv_sm;
  assign bus0.out_ready   = drv_out_ready;
  assign bus1.in_valid    = drv_in_valid;
  assign bus1.a           = drv_a;
  assign bus1.b           = drv_b;
  assign bus1.signed_mode = drv_sm;
  assign bus1.out_ready   = drv_out_ready;

  seq_shift_add_mult #(.WIDTH(W), .EARLY_TERM(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seq_shift_add_mult #(.WIDTH(W), .EARLY_TERM(1'b1)) dut_et (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer multiply of the operands as the mode says.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] av, input logic [W-1:0] bv,
                                                  input logic smv);
    int sa, sb, p;
    sa = smv ? int'($signed(av)) : int'(av);
    sb = smv ? int'($signed(bv)) : int'(bv);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Early-terminating latency: min(W, msb(|b|)+2), and 1 for b == 0.
  function automatic int ref_lat_et(input logic [W-1:0] bv, input logic smv);
    int m, msb;
    m = (smv && bv[W-1]) ? (256 - int'(bv)) : int'(bv);
    if (m == 0) return 1;
    msb = 0;
    for (int i = 0; i < 16; i++) if (((m >> i) & 1) == 1) msb = i;
    return (msb + 2 < W) ? msb + 2 : W;
  endfunction

  // One operation on both DUTs: accept, measure latency, check product,
  // optionally apply backpressure, then hand off (with in_valid also high).
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic smv,
                       input int hold, input string tag);
    logic [2*W-1:0] exp_p;
    int exp_l1, l0, l1, cyc;
    exp_p  = ref_product(av, bv, smv);
    exp_l1 = ref_lat_et(bv, smv);
    chk({tag, "_in_ready0"}, 32'(bus0.in_ready), 32'd1);
    chk({tag, "_in_ready1"}, 32'(bus1.in_ready), 32'd1);
    drv_in_valid = 1'b1; drv_a = av; drv_b = bv; drv_sm = smv;
    @(posedge clk); #1;
    drv_in_valid = 1'b0; drv_a = W'($urandom); drv_b = W'($urandom); drv_sm = 1'($urandom);
    l0 = -1; l1 = -1; cyc = 0;
    chk({tag, "_busy0"}, 32'(bus0.busy), 32'd1);
    chk({tag, "_busy1"}, 32'(bus1.busy), 32'd1);
    while ((l0 < 0 || l1 < 0) && cyc <= 40) begin
      @(posedge clk); #1;
      cyc++;
      if (l0 < 0 && bus0.out_valid === 1'b1) l0 = cyc;
      if (l1 < 0 && bus1.out_valid === 1'b1) l1 = cyc;
      if (l0 < 0) chk({tag, "_busy_mul0"}, 32'(bus0.busy), 32'd1);
    end
    chk({tag, "_lat0"}, 32'(l0), 32'(W));
    chk({tag, "_lat1"}, 32'(l1), 32'(exp_l1));
    chk({tag, "_prod0"}, 32'(bus0.product), 32'(exp_p));
    chk({tag, "_prod1"}, 32'(bus1.product), 32'(exp_p));
    for (int h = 0; h < hold; h++) begin
      drv_in_valid = h[0]; drv_a = W'($urandom); drv_b = W'($urandom);
      @(posedge clk); #1;
      chk({tag, "_bp_prod0"}, 32'(bus0.product), 32'(exp_p));
      chk({tag, "_bp_prod1"}, 32'(bus1.product), 32'(exp_p));
      chk({tag, "_bp_valid0"}, 32'(bus0.out_valid), 32'd1);
      chk({tag, "_bp_inrdy0"}, 32'(bus0.in_ready), 32'd0);
      chk({tag, "_bp_inrdy1"}, 32'(bus1.in_ready), 32'd0);
    end
    drv_out_ready = 1'b1; drv_in_valid = 1'b1;
    @(posedge clk); #1;
    drv_out_ready = 1'b0; drv_in_valid = 1'b0;
    chk({tag, "_ho_valid0"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, "_ho_valid1"}, 32'(bus1.out_valid), 32'd0);
    chk({tag, "_ho_inrdy0"}, 32'(bus0.in_ready), 32'd1);
    chk({tag, "_ho_busy1"}, 32'(bus1.busy), 32'd0);
    chk({tag, "_ho_prod0"}, 32'(bus0.product), 32'(exp_p));
    $display("op %s a=0x%02h b=0x%02h s=%0d prod=0x%04h exp=0x%04h lat=%0d/%0d",
             tag, av, bv, smv, bus0.product, exp_p, l0, l1);
  endtask

  logic [W-1:0]     pa [3];
  logic [W-1:0]     pb [3];
  logic             ps [3];
  logic [2*W-1:0]   expq [$];
  int               k, got;
  bit               acc_now;

  initial begin
    rst = 1'b1;
    drv_in_valid = 1'b0; drv_a = '0; drv_b = '0; drv_sm = 1'b0; drv_out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_product", 32'(bus0.product), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_et_product", 32'(bus1.product), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'd13,  8'd11,  1'b0, 0, "u13x11");
    do_op(8'hFB,  8'd7,   1'b1, 0, "s-5x7");
    do_op(8'h80,  8'h80,  1'b1, 0, "s-128x-128");
    do_op(8'hFF,  8'hFF,  1'b0, 0, "u255x255");
    do_op(8'd9,   8'd0,   1'b0, 0, "b0");
    do_op(8'd9,   8'd3,   1'b0, 0, "b3");
    do_op(8'd5,   8'h80,  1'b0, 0, "b80");
    do_op(8'd77,  8'd21,  1'b1, 5, "backpressure");

    for (int r = 0; r < 16; r++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of an operation (product holds a nonzero prior result).
    drv_in_valid = 1'b1; drv_a = 8'd7; drv_b = 8'd9; drv_sm = 1'b0;
    @(posedge clk); #1;
    drv_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("arst_product", 32'(bus0.product), 32'd0);
    chk("arst_in_ready", 32'(bus0.in_ready), 32'd1);
    chk("arst_busy", 32'(bus0.busy), 32'd0);
    chk("arst_et_product", 32'(bus1.product), 32'd0);
    $display("async reset mid-operation: in_ready=%0d product=0x%04h", bus0.in_ready, bus0.product);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_op(8'd6, 8'd6, 1'b0, 0, "after_rst");

    // Back-to-back: in_valid and out_ready held high on the full-latency unit.
    pa[0] = 8'd13;  pb[0] = 8'd11; ps[0] = 1'b0;
    pa[1] = 8'hFB;  pb[1] = 8'd7;  ps[1] = 1'b1;
    pa[2] = 8'd200; pb[2] = 8'd3;  ps[2] = 1'b0;
    k = 0; got = 0;
    expq.delete();
    drv_out_ready = 1'b1;
    drv_in_valid = 1'b1; drv_a = pa[0]; drv_b = pb[0]; drv_sm = ps[0];
    for (int cyc = 0; cyc < 200 && got < 3; cyc++) begin
      acc_now = (bus0.in_ready === 1'b1) && drv_in_valid;
      if (bus0.out_valid === 1'b1) begin
        if (expq.size() > 0) begin
          chk($sformatf("b2b_prod%0d", got), 32'(bus0.product), 32'(expq[0]));
          $display("b2b result %0d prod=0x%04h exp=0x%04h", got, bus0.product, expq[0]);
          void'(expq.pop_front());
        end else begin
          chk("b2b_spurious_valid", 32'(bus0.out_valid), 32'd0);
        end
        got++;
      end
      if (acc_now) expq.push_back(ref_product(pa[k], pb[k], ps[k]));
      @(posedge clk); #1;
      if (acc_now) begin
        k++;
        if (k < 3) begin
          drv_a = pa[k]; drv_b = pb[k]; drv_sm = ps[k];
        end else begin
          drv_in_valid = 1'b0;
        end
      end
    end
    drv_in_valid = 1'b0;
    drv_out_ready = 1'b0;
    chk("b2b_count", 32'(got), 32'd3);
    chk("b2b_accepts", 32'(k), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
